// File: rtl/cpu_bus_master_if.sv
// Signal bundle between an upstream command source, cpu_bus_master and a cpu_if slave.
// The master modport is the bus master's view; slave is the mirror used by whatever sits around it.
interface cpu_bus_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [29:0] req_addr;
    logic [31:0] req_wdata;

    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_rdata;
    logic [1:0]  rsp_status;

    logic        timeout;
    logic        read;
    logic        write;
    logic [29:0] address;
    logic [31:0] write_data;
    logic [31:0] read_data;
    logic        access_complete;
    logic        invalid_address;
    logic        invalid_access;

    modport master (
        input  req_valid, req_write, req_addr, req_wdata, rsp_ready,
               read_data, access_complete, invalid_address, invalid_access,
        output req_ready, rsp_valid, rsp_rdata, rsp_status,
               timeout, read, write, address, write_data
    );

    modport slave (
        output req_valid, req_write, req_addr, req_wdata, rsp_ready,
               read_data, access_complete, invalid_address, invalid_access,
        input  req_ready, rsp_valid, rsp_rdata, rsp_status,
               timeout, read, write, address, write_data
    );
endinterface

// File: rtl/cpu_bus_master.sv
// Single-outstanding CPU-bus master: takes one request, holds the bus strobe until the
// slave terminates or the timeout expires, then presents a held response.
module cpu_bus_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic             clk,
    input  logic             reset,
    cpu_bus_master_if.master io_bus
);
    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);

    localparam logic [1:0] ST_OK       = 2'b00;
    localparam logic [1:0] ST_BAD_ADDR = 2'b01;
    localparam logic [1:0] ST_BAD_ACC  = 2'b10;
    localparam logic [1:0] ST_TIMEOUT  = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ACCESS,
        S_ABORT,
        S_RESP
    } state_t;

    state_t             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_write_flag;
    logic               r_req_ready;
    logic               r_rsp_valid;
    logic [31:0]        r_rsp_rdata;
    logic [1:0]         r_rsp_status;
    logic               r_timeout;
    logic               r_read;
    logic               r_write;
    logic [29:0]        r_address;
    logic [31:0]        r_write_data;

    logic               w_term;

    assign w_term = io_bus.access_complete | io_bus.invalid_address | io_bus.invalid_access;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_write_flag <= 1'b0;
            r_req_ready  <= 1'b1;
            r_rsp_valid  <= 1'b0;
            r_rsp_rdata  <= '0;
            r_rsp_status <= ST_OK;
            r_timeout    <= 1'b0;
            r_read       <= 1'b0;
            r_write      <= 1'b0;
            r_address    <= '0;
            r_write_data <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (io_bus.req_valid) begin
                        r_address    <= io_bus.req_addr;
                        r_write_data <= io_bus.req_wdata;
                        r_write_flag <= io_bus.req_write;
                        r_read       <= !io_bus.req_write;
                        r_write      <= io_bus.req_write;
                        r_cnt        <= '0;
                        r_req_ready  <= 1'b0;
                        r_state      <= S_ACCESS;
                    end
                end
                // Termination beats counter expiry when both land on the same cycle.
                S_ACCESS: begin
                    if (w_term) begin
                        r_read      <= 1'b0;
                        r_write     <= 1'b0;
                        r_rsp_valid <= 1'b1;
                        r_state     <= S_RESP;
                        if (io_bus.invalid_address) begin
                            r_rsp_status <= ST_BAD_ADDR;
                            r_rsp_rdata  <= '0;
                        end else if (io_bus.invalid_access) begin
                            r_rsp_status <= ST_BAD_ACC;
                            r_rsp_rdata  <= '0;
                        end else begin
                            r_rsp_status <= ST_OK;
                            r_rsp_rdata  <= r_write_flag ? 32'd0 : io_bus.read_data;
                        end
                    end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
                        r_read    <= 1'b0;
                        r_write   <= 1'b0;
                        r_timeout <= 1'b1;
                        r_state   <= S_ABORT;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                S_ABORT: begin
                    r_timeout    <= 1'b0;
                    r_rsp_status <= ST_TIMEOUT;
                    r_rsp_rdata  <= '0;
                    r_rsp_valid  <= 1'b1;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    if (io_bus.rsp_ready) begin
                        r_rsp_valid <= 1'b0;
                        r_req_ready <= 1'b1;
                        r_state     <= S_IDLE;
                    end
                end
                default: begin
                    r_read      <= 1'b0;
                    r_write     <= 1'b0;
                    r_timeout   <= 1'b0;
                    r_rsp_valid <= 1'b0;
                    r_req_ready <= 1'b1;
                    r_state     <= S_IDLE;
                end
            endcase
        end
    end

    assign io_bus.req_ready  = r_req_ready;
    assign io_bus.rsp_valid  = r_rsp_valid;
    assign io_bus.rsp_rdata  = r_rsp_rdata;
    assign io_bus.rsp_status = r_rsp_status;
    assign io_bus.timeout    = r_timeout;
    assign io_bus.read       = r_read;
    assign io_bus.write      = r_write;
    assign io_bus.address    = r_address;
    assign io_bus.write_data = r_write_data;
endmodule

// File: tb/tb_cpu_bus_master.sv
// Bench for cpu_bus_master: default-timeout and short-timeout instances share one stimulus stream;
// the selected instance is compared against a transaction-level expectation model.
module tb_cpu_bus_master;
    localparam int unsigned TO_A = 16;
    localparam int unsigned TO_B = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    cpu_bus_master_if if_a();
    cpu_bus_master_if if_b();

    cpu_bus_master #(.TIMEOUT_CYCLES(TO_A)) u_dut_a (.clk(clk), .reset(reset), .io_bus(if_a));
    cpu_bus_master #(.TIMEOUT_CYCLES(TO_B)) u_dut_b (.clk(clk), .reset(reset), .io_bus(if_b));

    logic        req_valid, req_write, rsp_ready;
    logic        access_complete, invalid_address, invalid_access;
    logic [29:0] req_addr;
    logic [31:0] req_wdata, read_data;

    assign if_a.req_valid = req_valid;             assign if_b.req_valid = req_valid;
    assign if_a.req_write = req_write;             assign if_b.req_write = req_write;
    assign if_a.req_addr  = req_addr;              assign if_b.req_addr  = req_addr;
    assign if_a.req_wdata = req_wdata;             assign if_b.req_wdata = req_wdata;
    assign if_a.rsp_ready = rsp_ready;             assign if_b.rsp_ready = rsp_ready;
    assign if_a.read_data = read_data;             assign if_b.read_data = read_data;
    assign if_a.access_complete = access_complete; assign if_b.access_complete = access_complete;
    assign if_a.invalid_address = invalid_address; assign if_b.invalid_address = invalid_address;
    assign if_a.invalid_access  = invalid_access;  assign if_b.invalid_access  = invalid_access;

    logic sel_b;
    wire        obs_req_ready  = sel_b ? if_b.req_ready  : if_a.req_ready;
    wire        obs_rsp_valid  = sel_b ? if_b.rsp_valid  : if_a.rsp_valid;
    wire [31:0] obs_rsp_rdata  = sel_b ? if_b.rsp_rdata  : if_a.rsp_rdata;
    wire [1:0]  obs_rsp_status = sel_b ? if_b.rsp_status : if_a.rsp_status;
    wire        obs_timeout    = sel_b ? if_b.timeout    : if_a.timeout;
    wire        obs_read       = sel_b ? if_b.read       : if_a.read;
    wire        obs_write      = sel_b ? if_b.write      : if_a.write;
    wire [29:0] obs_address    = sel_b ? if_b.address    : if_a.address;
    wire [31:0] obs_write_data = sel_b ? if_b.write_data : if_a.write_data;

    int cur_to;
    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic clear_slave();
        access_complete = 1'b0;
        invalid_address = 1'b0;
        invalid_access  = 1'b0;
    endtask

    task automatic check_reset_vals();
        chk("rst_req_ready",  32'(obs_req_ready), 32'd1);
        chk("rst_rsp_valid",  32'(obs_rsp_valid), 32'd0);
        chk("rst_rsp_rdata",  obs_rsp_rdata, 32'd0);
        chk("rst_rsp_status", 32'(obs_rsp_status), 32'd0);
        chk("rst_timeout",    32'(obs_timeout), 32'd0);
        chk("rst_read",       32'(obs_read), 32'd0);
        chk("rst_write",      32'(obs_write), 32'd0);
        chk("rst_address",    32'(obs_address), 32'd0);
        chk("rst_write_data", obs_write_data, 32'd0);
    endtask

    // One access: term_at is the ACCESS cycle (1-based) in which the slave answers; outside
    // 1..cur_to it means the slave never answers in time and the access must time out.
    task automatic run_txn(input logic wr, input logic [29:0] addr, input logic [31:0] wdata,
                           input int term_at, input logic ia, input logic ix, input logic ac,
                           input logic [31:0] rd, input int hold, input logic keep_req);
        int          exp_k, exp_to, n_rd, n_wr, n_to, cyc;
        logic [1:0]  exp_st;
        logic [31:0] exp_rd;
        bit          done;

        if (term_at >= 1 && term_at <= cur_to) begin
            exp_k  = term_at;
            exp_to = 0;
            exp_st = ia ? 2'd1 : (ix ? 2'd2 : 2'd0);
            exp_rd = (exp_st == 2'd0 && !wr) ? rd : 32'd0;
        end else begin
            exp_k  = cur_to;
            exp_to = 1;
            exp_st = 2'd3;
            exp_rd = 32'd0;
        end

        chk("req_ready_idle", 32'(obs_req_ready), 32'd1);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("req_ready_busy", 32'(obs_req_ready), 32'd0);

        n_rd = 0; n_wr = 0; n_to = 0; cyc = 1; done = 0;
        while (!done && cyc < 200) begin
            if (obs_rsp_valid) begin
                done = 1;
            end else begin
                if (obs_read)    n_rd++;
                if (obs_write)   n_wr++;
                if (obs_timeout) n_to++;
                chk("strobe_excl", 32'(obs_read & obs_write), 32'd0);
                if (obs_read || obs_write) begin
                    chk("addr_stable",  32'(obs_address), 32'(addr));
                    chk("wdata_stable", obs_write_data, wdata);
                end
                if (obs_timeout)
                    chk("abort_strobes", 32'(obs_read | obs_write), 32'd0);
                read_data = $urandom;
                if (cyc == term_at) begin
                    access_complete = ac;
                    invalid_address = ia;
                    invalid_access  = ix;
                    read_data       = rd;
                end else if (obs_timeout) begin
                    access_complete = 1'b1;
                    invalid_address = 1'($urandom);
                    invalid_access  = 1'($urandom);
                end else begin
                    clear_slave();
                end
                @(posedge clk);
                @(negedge clk);
                cyc++;
            end
        end
        clear_slave();
        chk("rsp_within_bound", 32'(done), 32'd1);

        if (done) begin
            chk("rsp_latency",  32'(cyc), 32'(exp_k + exp_to + 1));
            chk("read_cycles",  32'(n_rd), wr ? 32'd0 : 32'(exp_k));
            chk("write_cycles", 32'(n_wr), wr ? 32'(exp_k) : 32'd0);
            chk("timeout_puls", 32'(n_to), 32'(exp_to));
            chk("rsp_status",   32'(obs_rsp_status), 32'(exp_st));
            chk("rsp_rdata",    obs_rsp_rdata, exp_rd);
            chk("resp_strobes", 32'(obs_read | obs_write | obs_timeout), 32'd0);

            for (int i = 0; i < hold; i++) begin
                rsp_ready = 1'b0;
                if (keep_req) begin
                    req_valid = 1'b1;
                    req_write = 1'($urandom);
                    req_addr  = 30'($urandom);
                    req_wdata = $urandom;
                end
                access_complete = 1'($urandom);
                invalid_address = 1'($urandom);
                invalid_access  = 1'($urandom);
                read_data       = $urandom;
                @(posedge clk);
                @(negedge clk);
                chk("hold_rsp_valid",  32'(obs_rsp_valid), 32'd1);
                chk("hold_rsp_status", 32'(obs_rsp_status), 32'(exp_st));
                chk("hold_rsp_rdata",  obs_rsp_rdata, exp_rd);
                chk("hold_req_ready",  32'(obs_req_ready), 32'd0);
            end
            rsp_ready = 1'b1;
            @(posedge clk);
            @(negedge clk);
            rsp_ready = 1'b0;
            clear_slave();
            if (!keep_req) req_valid = 1'b0;
            chk("post_hs_rsp_valid", 32'(obs_rsp_valid), 32'd0);
            chk("post_hs_req_ready", 32'(obs_req_ready), 32'd1);
        end
    endtask

    logic        r_wr, r_ia, r_ix, r_ac, r_keep;
    logic [29:0] r_addr;
    logic [31:0] r_wdata, r_rd;
    int          r_term, r_hold;

    initial begin
        reset = 1'b0;
        req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
        rsp_ready = 1'b0; read_data = '0;
        clear_slave();
        sel_b  = 1'b0;
        cur_to = TO_A;
        repeat (3) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        @(negedge clk);

        // Default timeout instance: directed cases
        run_txn(1'b0, 30'h10, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'hDEAD_BEEF, 0, 1'b0);
        run_txn(1'b1, 30'h0ABC_DE1, 32'h1234_5678, 5, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFF, 0, 1'b0);
        run_txn(1'b0, 30'h22, 32'h0, 1, 1'b1, 1'b1, 1'b1, 32'h5555_AAAA, 0, 1'b0);
        run_txn(1'b0, 30'h23, 32'h0, 2, 1'b0, 1'b1, 1'b0, 32'h5555_AAAA, 1, 1'b0);

        // Short timeout instance
        reset  = 1'b0;
        sel_b  = 1'b1;
        cur_to = TO_B;
        repeat (2) @(negedge clk);
        check_reset_vals();
        reset = 1'b1;
        @(negedge clk);

        run_txn(1'b0, 30'h31, 32'h0, 0, 1'b0, 1'b0, 1'b0, 32'h0, 0, 1'b0);
        run_txn(1'b1, 30'h32, 32'hCAFE_F00D, 4, 1'b0, 1'b0, 1'b1, 32'h0, 0, 1'b0);
        run_txn(1'b1, 30'h33, 32'h0BAD_CAFE, 2, 1'b0, 1'b0, 1'b1, 32'h0, 10, 1'b1);
        run_txn(1'b0, 30'h34, 32'h0, 1, 1'b0, 1'b0, 1'b1, 32'h1357_9BDF, 0, 1'b0);

        // Reset dropped asynchronously in the third ACCESS cycle
        chk("pre_rst_req_ready", 32'(obs_req_ready), 32'd1);
        req_valid = 1'b1; req_write = 1'b0; req_addr = 30'h77; req_wdata = '0;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        repeat (2) begin
            @(posedge clk);
            @(negedge clk);
        end
        chk("c3_read_high", 32'(obs_read), 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_read_drop",  32'(obs_read), 32'd0);
        chk("async_write_drop", 32'(obs_write), 32'd0);
        chk("async_rsp_valid",  32'(obs_rsp_valid), 32'd0);
        repeat (2) @(negedge clk);
        chk("in_rst_rsp_valid", 32'(obs_rsp_valid), 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("rel_req_ready", 32'(obs_req_ready), 32'd1);
        chk("rel_rsp_valid", 32'(obs_rsp_valid), 32'd0);
        run_txn(1'b0, 30'h78, 32'h0, 3, 1'b0, 1'b0, 1'b1, 32'hA5A5_0F0F, 0, 1'b0);

        for (int i = 0; i < 40; i++) begin
            r_wr    = 1'($urandom);
            r_addr  = 30'($urandom);
            r_wdata = $urandom;
            r_rd    = $urandom;
            r_term  = int'($urandom_range(0, TO_B + 1));
            r_ia    = 1'($urandom);
            r_ix    = 1'($urandom);
            r_ac    = 1'($urandom);
            if (!r_ia && !r_ix && !r_ac) r_ac = 1'b1;
            r_hold  = int'($urandom_range(0, 3));
            r_keep  = 1'($urandom);
            run_txn(r_wr, r_addr, r_wdata, r_term, r_ia, r_ix, r_ac, r_rd, r_hold, r_keep);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/cpu_bus_master.md
# cpu_bus_master

Request-side bus master that drives the `cpu_if` Master-side signal set (timeout, read, write, write_data, address) toward a CPU-bus slave, and collects that slave's response. It accepts one access at a time from an upstream command source over a valid/ready handshake and holds the bus request until the slave terminates it or a timeout expires. It returns the read data and a status code over a valid/ready response channel. It is the stage directly upstream of any `cpu_if` Slave.

## Interface
- `TIMEOUT_CYCLES`, 16, number of ACCESS cycles without termination before the access is aborted; legal range 1..1023.
- `clk` input 1: the single clock; all state updates on the rising edge.
- `reset` input 1: asynchronous, active-low reset.
- `req_valid` input 1: upstream request present.
- `req_ready` output 1: block can accept a request (high only in IDLE).
- `req_write` input 1: 1 = write, 0 = read.
- `req_addr` input 30 [31:2]: word address.
- `req_wdata` input 32: write data (ignored for reads).
- `rsp_valid` output 1: response held for downstream.
- `rsp_ready` input 1: downstream accepts the response.
- `rsp_rdata` output 32: read data; 0 for writes and errors.
- `rsp_status` output 2: 00 OK, 01 INVALID_ADDRESS, 10 INVALID_ACCESS, 11 TIMEOUT.
- `timeout` output 1: one-cycle abort pulse to the slave.
- `read`, `write` output 1 each: bus access strobes.
- `address` output 30 [31:2]; `write_data` output 32.
- `read_data` input 32; `access_complete`, `invalid_address`, `invalid_access` input 1 each: slave response.

## Operation
- FSM states: IDLE, ACCESS, ABORT, RESP.
- **IDLE:**
  - `req_ready`=1.
  - On `req_valid`: latch `req_addr` into `address`, `req_wdata` into `write_data`, and `req_write`; clear the timeout counter; go to ACCESS.
- **ACCESS:**
  - `read` = !write_flag; `write` = write_flag.
  - `address` and `write_data` are held stable.
  - Termination = `access_complete` | `invalid_address` | `invalid_access`, sampled each cycle.
  - On termination, capture the status with priority `invalid_address` > `invalid_access` > OK, then go to RESP.
  - `rsp_rdata` = `read_data` only for an OK read; otherwise 0.
  - With no termination, the counter increments.
  - If the counter reaches TIMEOUT_CYCLES-1 and there is no termination that cycle, go to ABORT.
  - If termination and counter expiry happen in the same cycle, termination wins.
- **ABORT:**
  - `timeout`=1 and `read`=`write`=0 for exactly one cycle.
  - Capture status 11 and rdata 0; go to RESP.
  - Any slave response seen in ABORT is ignored.
- **RESP:**
  - `rsp_valid`=1, with `rsp_rdata`/`rsp_status` stable and `read`=`write`=0.
  - On `rsp_ready`, go to IDLE.
  - Slave inputs are ignored.
- Counter width is clog2(TIMEOUT_CYCLES+1); it never wraps because it is cleared on every ACCESS entry.
- **Reset asserted mid-access:**
  - The bus strobes drop immediately (asynchronous).
  - No response is produced for the in-flight request.
  - The FSM is in IDLE when reset releases.

## Timing
- **Reset values:**
  - state IDLE, so `req_ready`=1.
  - `rsp_valid`=0, `rsp_rdata`=0, `rsp_status`=00.
  - `timeout`=0, `read`=0, `write`=0.
  - `address`=0, `write_data`=0.
- **Request acceptance and response latency:**
  - Request accepted at edge E0.
  - The bus strobe is high from E0 to E1 (the first ACCESS cycle).
  - A slave terminating combinationally in its first cycle gives `rsp_valid` after E1, so minimum request-to-response latency is 2 cycles.
  - Maximum ACCESS duration is TIMEOUT_CYCLES cycles, followed by 1 ABORT cycle.
- **Throughput:**
  - `req_ready` is low from E0 until the cycle after the response handshake.
  - Best-case throughput is one access per 3 cycles.
- **Response handshake:**
  - `rsp_valid` stays high until `rsp_ready`.
  - No response is dropped.
  - `rsp_rdata`/`rsp_status` never change while `rsp_valid`=1.
- **Strobes:** `read` and `write` are never high together, and both are low in every non-ACCESS state.

## Test plan
- **Read, immediate complete:**
  - Stimulus: read addr 0x0000_0040 (req_addr 0x10); the slave asserts `access_complete` in its 1st ACCESS cycle with `read_data`=0xDEAD_BEEF.
  - Required: `rsp_valid` 2 cycles after acceptance, rdata 0xDEAD_BEEF, status 00, `read` high exactly 1 cycle.
- **Write with wait states:**
  - Stimulus: write 0x1234_5678; complete on the 5th ACCESS cycle.
  - Required: `write` high for 5 cycles, `address`/`write_data` stable throughout, rdata 0, status 00.
- **Error priority:**
  - Stimulus: `invalid_address`, `invalid_access` and `access_complete` all raised in the same cycle.
  - Required: status 01, rdata 0.
  - Stimulus: `invalid_access` alone on a read.
  - Required: status 10, rdata 0.
- **Timeout boundary:**
  - Stimulus: TIMEOUT_CYCLES=4 and no slave response.
  - Required: the strobe is high 4 cycles, then `timeout` pulses 1 cycle, then status 11.
  - Stimulus: completion on exactly the 4th ACCESS cycle.
  - Required: status 00, no `timeout` pulse.
- **Response backpressure:**
  - Stimulus: hold `rsp_ready`=0 for 10 cycles while `req_valid` stays high with a new request.
  - Required: the response is held stable, `req_ready`=0 throughout, and the new request is accepted in the cycle after the handshake.
- **Reset mid-access:**
  - Stimulus: assert `reset` low asynchronously during ACCESS cycle 3.
  - Required: `read`/`write` drop without waiting for a clock edge, `rsp_valid` stays 0, `req_ready`=1 after release, and a following access completes normally.
